// File: rtl/deparser_do_deparsing_pkg.sv
// deparser_do_deparsing_pkg: shared widths, PHV field offsets, action layout and FSM states.
package deparser_do_deparsing_pkg;
  localparam int C_AXIS_DATA_WIDTH  = 256;
  localparam int C_AXIS_TUSER_WIDTH = 128;
  localparam int NUM_PER_TYPE       = 8;
  localparam int PKT_HDR_LEN        = (2+4+6)*8*NUM_PER_TYPE+256;
  localparam int C_NUM_SEGS         = 4;
  localparam int C_VLANID_WIDTH     = 12;
  localparam int SEG_W              = C_NUM_SEGS*C_AXIS_DATA_WIDTH;
  localparam int SEG_BYTES          = 128;
  localparam int NUM_ACTS           = 10;
  localparam int ACT_W              = 16;
  localparam int META_W             = 256;
  localparam int VLAN_POS           = 129;
  localparam int OFF_2B             = META_W;
  localparam int OFF_4B             = OFF_2B+16*NUM_PER_TYPE;
  localparam int OFF_6B             = OFF_4B+32*NUM_PER_TYPE;
  typedef enum logic [1:0] {CT_NONE = 2'b00, CT_2B = 2'b01, CT_4B = 2'b10, CT_6B = 2'b11} cont_type_e;
  typedef struct packed {
    logic [2:0] rsvd;
    logic [6:0] off;
    logic [2:0] idx;
    cont_type_e typ;
    logic       vld;
  } action_t;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_RAM, S_DEPARSE_A, S_DEPARSE_B, S_OUTPUT} state_e;
  // 01/10/11 encode 2/4/6 bytes, i.e. twice the type code
  function automatic logic [2:0] type_bytes(cont_type_e t);
    return {t, 1'b0};
  endfunction
endpackage

// File: rtl/deparser_do_deparsing_if.sv
// deparser_do_deparsing_if: PHV/segment inputs, action RAM port and deparsed output bundle.
interface deparser_do_deparsing_if;
  import deparser_do_deparsing_pkg::*;
  logic [PKT_HDR_LEN-1:0]        phv_in;
  logic                          phv_valid;
  logic                          phv_ready;
  logic [SEG_W-1:0]              tdata_segs;
  logic                          segs_valid;
  logic                          segs_ready;
  logic [C_VLANID_WIDTH-1:0]     bram_addr;
  logic [NUM_ACTS*ACT_W-1:0]     bram_out;
  logic [SEG_W-1:0]              depar_out_tdata_segs;
  logic [C_AXIS_TUSER_WIDTH-1:0] depar_out_tuser;
  logic                          depar_out_valid;
  logic                          depar_out_ready;
  modport master (
    output phv_in, phv_valid, tdata_segs, segs_valid, bram_out, depar_out_ready,
    input  phv_ready, segs_ready, bram_addr, depar_out_tdata_segs, depar_out_tuser, depar_out_valid
  );
  modport slave (
    input  phv_in, phv_valid, tdata_segs, segs_valid, bram_out, depar_out_ready,
    output phv_ready, segs_ready, bram_addr, depar_out_tdata_segs, depar_out_tuser, depar_out_valid
  );
endinterface

// File: rtl/deparser_do_deparsing_field_writer.sv
// deparse_field_writer: applies one deparse action to the 128-byte header buffer.
module deparse_field_writer
  import deparser_do_deparsing_pkg::*;
(
  input  logic [PKT_HDR_LEN-1:OFF_2B] cont_i,
  input  action_t                     act_i,
  input  logic [SEG_W-1:0]            buf_i,
  output logic [SEG_W-1:0]            buf_o
);
  logic [2:0]  n;
  logic [47:0] cont;
  logic        en;
  logic        unused_rsvd;
  assign unused_rsvd = ^act_i.rsvd;
  always_comb begin
    n    = type_bytes(act_i.typ);
    cont = act_i.typ == CT_2B ? 48'(cont_i[OFF_2B+act_i.idx*16 +: 16]) :
           act_i.typ == CT_4B ? 48'(cont_i[OFF_4B+act_i.idx*32 +: 32]) :
                                cont_i[OFF_6B+act_i.idx*48 +: 48];
    en   = act_i.vld && act_i.typ != CT_NONE && 8'(act_i.off) + 8'(n) <= 8'(SEG_BYTES);
    buf_o = buf_i;
    // container MSB byte lands at the lowest wire byte
    for (int b = 0; b < 6; b++)
      if (en && b < int'(n)) buf_o[(int'(act_i.off)+b)*8 +: 8] = cont[(int'(n)-1-b)*8 +: 8];
  end
endmodule

// File: rtl/deparser_do_deparsing.sv
// deparser_do_deparsing: writes PHV containers back into the header segments using
// ten per-VLAN actions from an external action RAM, five actions per cycle.
module deparser_do_deparsing
  import deparser_do_deparsing_pkg::*;
(
  input logic              axis_clk,
  input logic              aresetn,
  deparser_do_deparsing_if.slave dp
);
  state_e                        state_q;
  logic [PKT_HDR_LEN-1:OFF_2B]   cont_q;
  logic [SEG_W-1:0]              buf_q, data_q;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q;
  logic [5*ACT_W-1:0]            acts_q;
  logic [C_VLANID_WIDTH-1:0]     addr_q;
  logic                          valid_q;
  logic                          accept;
  logic                          unused_meta;
  action_t                       act [5];
  logic [SEG_W-1:0]              chain [6];
  assign accept                  = aresetn && state_q == S_IDLE && dp.phv_valid && dp.segs_valid;
  assign dp.phv_ready            = accept;
  assign dp.segs_ready           = accept;
  assign dp.bram_addr            = addr_q;
  assign dp.depar_out_tdata_segs = data_q;
  assign dp.depar_out_tuser      = tuser_q;
  assign dp.depar_out_valid      = valid_q;
  assign unused_meta             = ^{dp.phv_in[META_W-1:VLAN_POS+C_VLANID_WIDTH], dp.phv_in[VLAN_POS-1:C_AXIS_TUSER_WIDTH]};
  assign chain[0]                = buf_q;
  // one shared chain: actions 0-4 straight from RAM, then 5-9 from the latched copy
  for (genvar k = 0; k < 5; k++) begin : g_w
    assign act[k] = state_q == S_DEPARSE_A ? action_t'(dp.bram_out[(NUM_ACTS-1-k)*ACT_W +: ACT_W])
                                           : action_t'(acts_q[(4-k)*ACT_W +: ACT_W]);
    deparse_field_writer u_w (.cont_i(cont_q), .act_i(act[k]), .buf_i(chain[k]), .buf_o(chain[k+1]));
  end
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      cont_q  <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      tuser_q <= '0;
      acts_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          cont_q  <= dp.phv_in[PKT_HDR_LEN-1:OFF_2B];
          buf_q   <= dp.tdata_segs;
          tuser_q <= dp.phv_in[C_AXIS_TUSER_WIDTH-1:0];
          addr_q  <= dp.phv_in[VLAN_POS +: C_VLANID_WIDTH];
          state_q <= S_WAIT_RAM;
        end
        S_WAIT_RAM: state_q <= S_DEPARSE_A;
        S_DEPARSE_A: begin
          acts_q  <= dp.bram_out[5*ACT_W-1:0];
          buf_q   <= chain[5];
          state_q <= S_DEPARSE_B;
        end
        S_DEPARSE_B: begin
          data_q  <= chain[5];
          valid_q <= 1'b1;
          state_q <= S_OUTPUT;
        end
        S_OUTPUT: if (dp.depar_out_ready) begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
